c64_bus_arbiter: RTL and testbench

//   Shares the single system memory bus between the 6502 core and the VIC-II

---
 rtl/c64_bus_arbiter.sv | 115 +++++++++++
 tb/tb_c64_bus_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/c64_bus_arbiter.sv
// c64_bus_arbiter
//   Time-multiplexes the shared memory bus between the 6502 core and the VIC-II
//   fetcher. Every rising clk edge closes one bus slot. Phase 0 slots always
//   belong to the VIC. Phase 1 slots belong to the CPU unless a steal is in
//   progress. A steal request drops BA (cpu_rdy) at once. The CPU is then
//   granted BA_DELAY more slots, after which the VIC takes both phases.
//
// Ports
//   clk, reset           clock (one slot per edge), async active-high reset
//   cpu_ab/we/do         CPU address, write enable, write data
//   cpu_di               registered read data returned to the CPU
//   cpu_ce               CPU clock enable, high during a granted CPU slot
//   cpu_rdy              BA; low while a steal is pending or active
//   vic_addr/bank        VIC fetch address and bank (bank = mem_addr[15:14])
//   vic_steal_req        VIC wants the CPU slots too
//   vic_data             registered read data returned to the VIC
//   vic_aec              high while the VIC owns the current slot
//   mem_addr/we/wdata    shared memory bus (combinational from phase/state)
//   mem_rdata            asynchronous-read memory data
module c64_bus_arbiter #(
  parameter int unsigned BA_DELAY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  output logic [7:0]  cpu_di,
  output logic        cpu_ce,
  output logic        cpu_rdy,
  input  logic [13:0] vic_addr,
  input  logic [1:0]  vic_bank,
  input  logic        vic_steal_req,
  output logic [7:0]  vic_data,
  output logic        vic_aec,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {NORMAL, BA_WAIT, STEAL} state_t;

  localparam logic [2:0] DLY = 3'(BA_DELAY);

  logic       phase;
  state_t     state;
  logic [2:0] count;
  logic       vic_slot;

  // Slot owner decode. Reset forces phase 0, so the bus falls back to the VIC
  // and no write strobe can escape while reset is held.
  assign vic_slot  = ~phase | (state == STEAL);
  assign vic_aec   = vic_slot;
  assign cpu_ce    = ~vic_slot;
  assign mem_addr  = vic_slot ? {vic_bank, vic_addr} : cpu_ab;
  assign mem_we    = ~vic_slot & cpu_we;
  assign mem_wdata = cpu_do;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= 1'b0;
      state    <= NORMAL;
      count    <= 3'd0;
      cpu_rdy  <= 1'b1;
      cpu_di   <= 8'h00;
      vic_data <= 8'h00;
    end else begin
      phase <= ~phase;

      // Read data is latched at the edge that closes the slot.
      if (vic_slot)     vic_data <= mem_rdata;
      else if (!cpu_we) cpu_di   <= mem_rdata;

      case (state)
        NORMAL: begin
          if (vic_steal_req) begin
            state   <= BA_WAIT;
            count   <= 3'd0;
            cpu_rdy <= 1'b0;
          end
        end
        BA_WAIT: begin
          if (!vic_steal_req) begin
            // Abort: the request vanished before the steal began.
            state   <= NORMAL;
            cpu_rdy <= 1'b1;
          end else if (phase) begin
            // A granted CPU slot just closed. When it is the BA_DELAY-th one,
            // the next phase-1 slot goes to the VIC. count saturates there.
            if (count == DLY - 3'd1) begin
              state <= STEAL;
              count <= DLY;
            end else if (count != DLY) begin
              count <= count + 3'd1;
            end
          end
        end
        STEAL: begin
          // Release only at the end of a phase-1 slot so a release seen in
          // phase 0 still leaves the following phase-1 slot with the VIC.
          if (!vic_steal_req && phase) begin
            state   <= NORMAL;
            cpu_rdy <= 1'b1;
          end
        end
        default: begin
          state   <= NORMAL;
          cpu_rdy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Bench for c64_bus_arbiter. A slot-level model predicts ownership and data
// every cycle. Directed scenarios add hand-computed literal expectations.
module tb_c64_bus_arbiter;

  localparam int BA_DELAY = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_ce;
  logic        cpu_rdy;
  logic [13:0] vic_addr;
  logic [1:0]  vic_bank;
  logic        vic_steal_req;
  logic [7:0]  vic_data;
  logic        vic_aec;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  c64_bus_arbiter #(.BA_DELAY(BA_DELAY)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do), .cpu_di(cpu_di),
    .cpu_ce(cpu_ce), .cpu_rdy(cpu_rdy),
    .vic_addr(vic_addr), .vic_bank(vic_bank), .vic_steal_req(vic_steal_req),
    .vic_data(vic_data), .vic_aec(vic_aec),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x1234 holds 0xA5, everything else a hash of the address.
  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign mem_rdata = memf(mem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Slot model: mode 0 = CPU has phase 1, 1 = BA low with m_left CPU slots
  // still owed, 2 = VIC owns every slot.
  logic       m_phase;
  int         m_mode;
  int         m_left;
  logic       m_rdy;
  logic [7:0] m_di, m_vd;
  logic       m_vown;
  logic [15:0] m_addr;

  assign m_vown = !m_phase || (m_mode == 2);
  assign m_addr = m_vown ? {vic_bank, vic_addr} : cpu_ab;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 1'b0; m_mode <= 0; m_left <= 0; m_rdy <= 1'b1;
      m_di <= 8'h00; m_vd <= 8'h00;
    end else begin
      m_phase <= !m_phase;
      if (m_vown) m_vd <= memf(m_addr);
      else if (!cpu_we) m_di <= memf(m_addr);
      if (m_mode == 0) begin
        if (vic_steal_req) begin m_mode <= 1; m_left <= BA_DELAY; m_rdy <= 1'b0; end
      end else if (m_mode == 1) begin
        if (!vic_steal_req) begin m_mode <= 0; m_rdy <= 1'b1; end
        else if (m_phase) begin
          m_left <= m_left - 1;
          if (m_left == 1) m_mode <= 2;
        end
      end else begin
        if (!vic_steal_req && m_phase) begin m_mode <= 0; m_rdy <= 1'b1; end
      end
    end
  end

  // Per-cycle compare plus running event counters used by the scenarios.
  int   ce_rdy0 = 0, we_rdy0 = 0, vic_pairs = 0;
  logic prev_aec = 1'b0;

  always @(negedge clk) begin
    chk("vic_aec",   {31'b0, vic_aec}, {31'b0, m_vown});
    chk("cpu_ce",    {31'b0, cpu_ce},  {31'b0, !m_vown});
    chk("cpu_rdy",   {31'b0, cpu_rdy}, {31'b0, m_rdy});
    chk("mem_addr",  {16'b0, mem_addr}, {16'b0, m_addr});
    chk("mem_we",    {31'b0, mem_we},  {31'b0, !m_vown && cpu_we});
    chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, cpu_do});
    chk("cpu_di",    {24'b0, cpu_di},  {24'b0, m_di});
    chk("vic_data",  {24'b0, vic_data}, {24'b0, m_vd});
    if (!cpu_rdy && cpu_ce) ce_rdy0 <= ce_rdy0 + 1;
    if (!cpu_rdy && mem_we) we_rdy0 <= we_rdy0 + 1;
    if (!cpu_rdy && vic_aec && prev_aec) vic_pairs <= vic_pairs + 1;
    prev_aec <= vic_aec;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int c0, c1, c2;

  initial begin
    reset = 1'b1; cpu_ab = 16'h1234; cpu_we = 1'b1; cpu_do = 8'h00;
    vic_addr = 14'h0400; vic_bank = 2'd0; vic_steal_req = 1'b0;
    tick(2);
    // Reset state, with cpu_we high to show no write leaks out.
    chk("rst_rdy",  {31'b0, cpu_rdy}, 32'd1);
    chk("rst_ce",   {31'b0, cpu_ce},  32'd0);
    chk("rst_aec",  {31'b0, vic_aec}, 32'd1);
    chk("rst_we",   {31'b0, mem_we},  32'd0);
    chk("rst_di",   {24'b0, cpu_di},  32'h00);
    chk("rst_vd",   {24'b0, vic_data}, 32'h00);
    cpu_we = 1'b0;
    reset = 1'b0;

    // 1: plain alternation.
    chk("t1_vic_addr", {16'b0, mem_addr}, 32'h0400);
    tick();
    chk("t1_cpu_addr", {16'b0, mem_addr}, 32'h1234);
    chk("t1_cpu_ce",   {31'b0, cpu_ce},   32'd1);
    chk("t1_vic_data", {24'b0, vic_data}, 32'h38);
    tick();
    chk("t1_cpu_di",   {24'b0, cpu_di},   32'hA5);
    chk("t1_ce_low",   {31'b0, cpu_ce},   32'd0);
    tick(3);

    // 2: long steal.
    c0 = ce_rdy0; c1 = we_rdy0; c2 = vic_pairs;
    vic_steal_req = 1'b1;
    tick();
    chk("t2_rdy_drop", {31'b0, cpu_rdy}, 32'd0);
    tick(39);
    vic_steal_req = 1'b0;
    tick(3);
    chk("t2_ce_pulses", ce_rdy0 - c0, 32'd3);
    chk("t2_no_write",  we_rdy0 - c1, 32'd0);
    chk("t2_stolen",    {31'b0, (vic_pairs - c2) > 10}, 32'd1);
    tick(2);

    // 3: release in a phase-0 stolen slot.
    vic_steal_req = 1'b1;
    tick(10);
    for (int i = 0; i < 3 && m_phase != 1'b0; i++) tick();
    chk("t3_aligned", {31'b0, m_phase}, 32'd0);
    vic_steal_req = 1'b0;
    tick();
    chk("t3_still_aec", {31'b0, vic_aec}, 32'd1);
    chk("t3_still_rdy", {31'b0, cpu_rdy}, 32'd0);
    tick();
    chk("t3_rdy_back", {31'b0, cpu_rdy}, 32'd1);
    tick();
    chk("t3_cpu_slot", {31'b0, cpu_ce}, 32'd1);
    tick(2);

    // 4: abort inside the wait window, then a fresh request.
    c2 = vic_pairs;
    vic_steal_req = 1'b1;
    tick(3);
    vic_steal_req = 1'b0;
    tick();
    chk("t4_rdy_back", {31'b0, cpu_rdy}, 32'd1);
    chk("t4_no_steal", vic_pairs - c2, 32'd0);
    tick(2);
    c0 = ce_rdy0;
    vic_steal_req = 1'b1;
    tick(20);
    vic_steal_req = 1'b0;
    tick(3);
    chk("t4_restart_pulses", ce_rdy0 - c0, 32'd3);
    tick(2);

    // 5: CPU writes during the wait window, VIC in bank 2.
    vic_bank = 2'd2;
    c1 = we_rdy0;
    cpu_ab = 16'hD020; cpu_do = 8'h5A; cpu_we = 1'b1;
    vic_steal_req = 1'b1;
    tick();
    if (!vic_aec) chk("t5_bus", {8'h0, mem_we, 7'h0, mem_addr}, 32'h0080D020);
    else chk("t5_vic_bank", {16'b0, mem_addr}, 32'h8400);
    tick(19);
    cpu_we = 1'b0; vic_steal_req = 1'b0;
    tick(3);
    chk("t5_writes", we_rdy0 - c1, 32'd3);
    tick(2);

    // 6: reset in the middle of a steal.
    cpu_ab = 16'h1234; vic_bank = 2'd0;
    vic_steal_req = 1'b1;
    tick(12);
    cpu_we = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t6_aec", {31'b0, vic_aec}, 32'd1);
    chk("t6_rdy", {31'b0, cpu_rdy}, 32'd1);
    chk("t6_ce",  {31'b0, cpu_ce},  32'd0);
    chk("t6_we",  {31'b0, mem_we},  32'd0);
    chk("t6_vd",  {24'b0, vic_data}, 32'h00);
    chk("t6_addr", {16'b0, mem_addr}, 32'h0400);
    vic_steal_req = 1'b0; cpu_we = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("t6_ph0_vic", {31'b0, vic_aec}, 32'd1);
    tick();
    chk("t6_cpu_slot", {31'b0, cpu_ce}, 32'd1);
    tick();
    chk("t6_cpu_di", {24'b0, cpu_di}, 32'hA5);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
